// File: rtl/count_capture_fifo_pkg.sv
// Shared definitions for the count capture FIFO slice.
// Holds the default data width (shared with the up-counter), the legal DEPTH
// range, and helpers for the pointer width and the DEPTH legality check.
package count_capture_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;   // counter output width
    localparam int DEFAULT_DEPTH = 4;
    localparam int MIN_DEPTH     = 2;
    localparam int MAX_DEPTH     = 16;

    // Pointer width for a power-of-two DEPTH.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // DEPTH must be a power of two inside [MIN_DEPTH, MAX_DEPTH] so that the
    // pointers can wrap by simple overflow.
    function automatic bit depth_legal(input int depth);
        return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/count_capture_fifo_if.sv
// Bus interface of the count capture FIFO.
// master : drives count_in, capture, rd_en, clr_ovf; observes FIFO status.
// slave  : the FIFO itself; returns rd_data/rd_valid, empty/full/level and
//          the sticky overflow flag.
interface count_capture_fifo_if
    import count_capture_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int LVL_W = addr_w(DEPTH) + 1;

    logic [WIDTH-1:0] count_in;
    logic             capture;
    logic             rd_en;
    logic             clr_ovf;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [LVL_W-1:0] level;
    logic             overflow;

    modport master (
        output count_in, capture, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, level, overflow
    );

    modport slave (
        input  count_in, capture, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, level, overflow
    );
endinterface

// File: rtl/count_capture_fifo_capture_edge_det.sv
// Rising-edge detector for the capture strobe.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-high reset (clears the history register)
//   i_capture - capture strobe, synchronous to clk
//   o_cap_evt - single-cycle event on the first high cycle of i_capture
module capture_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_capture,
    output logic o_cap_evt
);
    logic r_capture_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_capture_q <= 1'b0;
        end else begin
            r_capture_q <= i_capture;
        end
    end

    // Held-high strobes produce only one event.
    assign o_cap_evt = i_capture & ~r_capture_q;
endmodule

// File: rtl/count_capture_fifo.sv
// Count capture FIFO: snapshots the live counter value on a capture event and
// buffers the snapshots for a slower reader.
// Ports:
//   clk   - system clock, all state on its rising edge
//   reset - asynchronous active-high reset, discards all stored entries
//   bus   - slave side of count_capture_fifo_if (count_in, capture, rd_en,
//           clr_ovf in; rd_data, rd_valid, empty, full, level, overflow out)
module count_capture_fifo
    import count_capture_fifo_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int CAPTURE_EDGE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    count_capture_fifo_if.slave   bus
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("count_capture_fifo: DEPTH must be a power of two in 2..16");
    end

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow;

    logic w_cap_evt;
    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_drop;

    if (CAPTURE_EDGE != 0) begin : g_edge
        capture_edge_det u_edge_det (
            .clk       (clk),
            .reset     (reset),
            .i_capture (bus.capture),
            .o_cap_evt (w_cap_evt)
        );
    end else begin : g_level
        assign w_cap_evt = bus.capture;
    end

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LEVEL);

    // A read on empty is ignored, so a capture into an empty FIFO is never
    // bypassed to the read side. A capture into a full FIFO succeeds only if
    // a real read frees the slot in the same cycle.
    assign w_rd_ok = bus.rd_en && !w_empty;
    assign w_wr_ok = w_cap_evt && (!w_full || w_rd_ok);
    assign w_drop  = w_cap_evt && !w_wr_ok;

    // Storage has no reset; level gating guarantees that unwritten entries
    // are never popped.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.count_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                // When full with a simultaneous write, wr_ptr == rd_ptr; the
                // nonblocking read still returns the old (oldest) entry.
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // A fresh drop outranks a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_count_capture_fifo.sv
module tb_count_capture_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    count_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CAPTURE_EDGE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_data = '0;
    bit               m_valid = 1'b0;
    bit               m_ovf = 1'b0;
    bit               m_cap_prev = 1'b0;

    task automatic model_step();
        int had;
        bit evt, do_rd, do_wr;
        evt        = bus.capture && !m_cap_prev;
        m_cap_prev = bus.capture;
        had        = m_q.size();
        do_rd      = bus.rd_en && (had > 0);
        do_wr      = evt && ((had < DEPTH) || do_rd);
        m_valid    = do_rd;
        if (do_rd) m_data = m_q.pop_front();
        if (do_wr) m_q.push_back(bus.count_in);
        if (evt && !do_wr) m_ovf = 1'b1;
        else if (bus.clr_ovf) m_ovf = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_data     = '0;
                m_valid    = 1'b0;
                m_ovf      = 1'b0;
                m_cap_prev = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_level",    32'(bus.level),    32'(m_q.size()));
            chk("cmp_empty",    32'(bus.empty),    32'(m_q.size() == 0));
            chk("cmp_full",     32'(bus.full),     32'(m_q.size() == DEPTH));
            chk("cmp_overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("cmp_rd_valid", 32'(bus.rd_valid), 32'(m_valid));
            chk("cmp_rd_data",  32'(bus.rd_data),  32'(m_data));
            if (bus.rd_valid)
                $display("read: data=%0d level=%0d t=%0t", bus.rd_data, bus.level, $time);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic [7:0] c, input logic cap, input logic rd, input logic clr);
        @(negedge clk);
        bus.count_in = c;
        bus.capture  = cap;
        bus.rd_en    = rd;
        bus.clr_ovf  = clr;
    endtask

    task automatic read_expect(input string name, input logic [7:0] exp);
        cyc(8'd0, 1'b0, 1'b1, 1'b0);
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
        chk({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({name, "_data"},  32'(bus.rd_data),  32'(exp));
    endtask

    task automatic capture_at(input logic [7:0] c);
        cyc(c, 1'b1, 1'b0, 1'b0);
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.count_in = '0;
        bus.capture  = 1'b0;
        bus.rd_en    = 1'b0;
        bus.clr_ovf  = 1'b0;

        // Power-on reset values
        #1;
        chk("por_empty", 32'(bus.empty), 32'd1);
        chk("por_level", 32'(bus.level), 32'd0);
        chk("por_rd_valid", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1. Store something, then assert reset mid-cycle
        capture_at(8'd77);
        read_expect("t1_pre", 8'd77);
        capture_at(8'd78);
        #2 reset = 1'b1;
        #1;
        chk("t1_rst_empty", 32'(bus.empty), 32'd1);
        chk("t1_rst_level", 32'(bus.level), 32'd0);
        chk("t1_rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("t1_rst_full", 32'(bus.full), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 2. Counter running from 5, capture at 9
        for (int c = 5; c < 9; c++) cyc(8'(c), 1'b0, 1'b0, 1'b0);
        cyc(8'd9, 1'b1, 1'b0, 1'b0);
        cyc(8'd10, 1'b0, 1'b0, 1'b0);
        chk("t2_level", 32'(bus.level), 32'd1);
        cyc(8'd11, 1'b0, 1'b1, 1'b0);
        cyc(8'd12, 1'b0, 1'b0, 1'b0);
        chk("t2_valid", 32'(bus.rd_valid), 32'd1);
        chk("t2_data", 32'(bus.rd_data), 32'd9);
        chk("t2_empty", 32'(bus.empty), 32'd1);
        cyc(8'd13, 1'b0, 1'b0, 1'b0);
        chk("t2_valid_pulse", 32'(bus.rd_valid), 32'd0);

        // 3. Held capture stores exactly one entry
        for (int c = 20; c < 25; c++) cyc(8'(c), 1'b1, 1'b0, 1'b0);
        cyc(8'd25, 1'b0, 1'b0, 1'b0);
        chk("t3_level", 32'(bus.level), 32'd1);
        read_expect("t3_read", 8'd20);

        // 4. Fill and overflow
        for (int c = 10; c <= 18; c += 2) capture_at(8'(c));
        chk("t4_full", 32'(bus.full), 32'd1);
        chk("t4_level", 32'(bus.level), 32'd4);
        chk("t4_ovf", 32'(bus.overflow), 32'd1);
        for (int c = 10; c <= 16; c += 2) read_expect("t4_drain", 8'(c));
        chk("t4_empty", 32'(bus.empty), 32'd1);
        chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
        chk("t4_ovf_clr", 32'(bus.overflow), 32'd0);

        // 5. Simultaneous read/write when full
        for (int c = 1; c <= 4; c++) capture_at(8'(c));
        chk("t5_full", 32'(bus.full), 32'd1);
        cyc(8'd50, 1'b1, 1'b1, 1'b0);
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
        chk("t5_data", 32'(bus.rd_data), 32'd1);
        chk("t5_level", 32'(bus.level), 32'd4);
        chk("t5_ovf", 32'(bus.overflow), 32'd0);
        read_expect("t5_d2", 8'd2);
        read_expect("t5_d3", 8'd3);
        read_expect("t5_d4", 8'd4);
        read_expect("t5_d50", 8'd50);

        // 5b. Capture + read on empty: write kept, read ignored
        cyc(8'd60, 1'b1, 1'b1, 1'b0);
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
        chk("t5b_valid", 32'(bus.rd_valid), 32'd0);
        chk("t5b_level", 32'(bus.level), 32'd1);
        read_expect("t5b_read", 8'd60);

        // 6. Interleaved pairs across pointer wrap, then reset mid-stream
        for (int i = 0; i < 10; i++) begin
            cyc(8'(100 + i), 1'b1, 1'b0, 1'b0);
            read_expect("t6_pair", 8'(100 + i));
        end
        capture_at(8'd200);
        capture_at(8'd201);
        chk("t6_level2", 32'(bus.level), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_empty", 32'(bus.empty), 32'd1);
        chk("t6_rst_level", 32'(bus.level), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(8'd0, 1'b0, 1'b1, 1'b0);
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
        chk("t6_no_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_rd_data_hold", 32'(bus.rd_data), 32'd0);
        cyc(8'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
